// File: rtl/moore_seq_det.sv
// moore_seq_det -- parametrised Moore serial pattern detector.
//
// Tracks the longest matched prefix of a runtime-loadable N-bit pattern over
// the accepted (din_vld=1) bit history. Overlapping or non-overlapping
// detection is selected by the overlap input. An optional saturating match
// counter is kept.
//
// Build option:
//   MOORE_SEQ_CNT_EN  defined   -> match counter present, saturating at 2^CNT_W-1
//                     undefined -> no counter register, match_cnt tied to 0
//
// Parameters:
//   N         pattern length (2..16)
//   CNT_W     match counter width (1..16)
//   PAT_INIT  pattern after reset, bit 0 is the first bit expected
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din_vld    qualifies din
//   din        serial data bit
//   overlap    1 = overlapping, 0 = non-overlapping detection
//   pat_load   load pat_in into the pattern register (priority over din_vld)
//   pat_in     new pattern, bit 0 first
//   qout       registered match flag, high iff state == N
//   state      matched-prefix length 0..N
//   match_cnt  saturating match count
//
// state | meaning
// ------+-------------------------------------------
//   0   | no pattern prefix matched
//   k   | first k pattern bits matched (0 < k < N)
//   N   | full pattern matched, qout high
module moore_seq_det #(
  parameter int             N        = 4,
  parameter int             CNT_W    = 8,
  parameter logic [N-1:0]   PAT_INIT = 4'b1101
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_vld,
  input  logic                     din,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  output logic                     qout,
  output logic [$clog2(N+1)-1:0]   state,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int SW = $clog2(N+1);
  localparam logic [SW-1:0] S_FULL = SW'(N);

  logic [N-1:0]  pat_q;
  logic [SW-1:0] state_q;
  logic          qout_q;
  logic [SW-1:0] nxt;
  logic          accept;
  int            s_cur;
  int            s_eff;
  logic          ok;

  // Pattern bit at a runtime index; a shift keeps the select width-clean.
  function automatic logic pbit(input logic [N-1:0] p, input int i);
    logic [N-1:0] t;
    t = p >> i;
    return t[0];
  endfunction

  assign accept = din_vld && !pat_load;

  // Failure-function step. The candidate string is the first s_eff pattern
  // bits followed by din; the next state is the longest pattern prefix that
  // is a suffix of that candidate. Ascending k with overwrite means the
  // largest matching k wins.
  always_comb begin
    s_cur = int'(state_q);
    if (s_cur == N) s_eff = overlap ? N : 0;
    else            s_eff = s_cur;
    nxt = '0;
    ok  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      ok = (k <= s_eff + 1) && (din == pbit(pat_q, k - 1));
      for (int j = 0; j < N - 1; j++) begin
        if (ok && (j < k - 1) && (pbit(pat_q, s_eff + 1 - k + j) != pbit(pat_q, j)))
          ok = 1'b0;
      end
      if (ok) nxt = SW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PAT_INIT;
      state_q <= '0;
      qout_q  <= 1'b0;
    end else if (pat_load) begin
      pat_q   <= pat_in;
      state_q <= '0;
      qout_q  <= 1'b0;
    end else if (din_vld) begin
      state_q <= nxt;
      qout_q  <= (nxt == S_FULL);
    end
  end

`ifdef MOORE_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (accept && (nxt == S_FULL) && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign qout  = qout_q;
  assign state = state_q;

endmodule

// File: tb/tb_moore_seq_det.sv
module tb_moore_seq_det;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int SW    = 3;
  localparam logic [N-1:0] PAT_INIT = 4'b1101;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din_vld = 1'b0;
  logic             din = 1'b0;
  logic             overlap = 1'b1;
  logic             pat_load = 1'b0;
  logic [N-1:0]     pat_in = '0;
  logic             qout;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;

  moore_seq_det #(.N(N), .CNT_W(CNT_W), .PAT_INIT(PAT_INIT)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .qout(qout), .state(state),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the accepted bit history (last N bits since the last
  // clear) and the pattern; state is recomputed from the history each step.
  bit         hist[$];
  logic [N-1:0] m_pat = PAT_INIT;
  int         m_s   = 0;
  int         m_cnt = 0;

  function automatic int longest_prefix_suffix();
    int best;
    bit m;
    best = 0;
    for (int k = 1; k <= N; k++) begin
      if (k <= hist.size()) begin
        m = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[hist.size() - k + j] != m_pat[j]) m = 1'b0;
        if (m) best = k;
      end
    end
    return best;
  endfunction

  task automatic check(input string tag);
    logic [SW-1:0]    es;
    logic             eq;
    logic [CNT_W-1:0] ec;
    es = SW'(m_s);
    eq = (m_s == N);
`ifdef MOORE_SEQ_CNT_EN
    ec = CNT_W'(m_cnt);
`else
    ec = '0;
`endif
    total++;
    assert (state === es) else begin
      bad++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, es);
    end
    total++;
    assert (qout === eq) else begin
      bad++;
      $error("FAIL %s qout observed=%0b expected=%0b", tag, qout, eq);
    end
    total++;
    assert (match_cnt === ec) else begin
      bad++;
      $error("FAIL %s match_cnt observed=%0d expected=%0d", tag, match_cnt, ec);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic d, input logic ov,
                      input logic ld, input logic [N-1:0] pi, input string tag);
    rst = r; din_vld = v; din = d; overlap = ov; pat_load = ld; pat_in = pi;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete(); m_pat = PAT_INIT; m_s = 0; m_cnt = 0;
    end else if (ld) begin
      hist.delete(); m_pat = pi; m_s = 0;
    end else if (v) begin
      if (m_s == N && !ov) hist.delete();
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      m_s = longest_prefix_suffix();
      if (m_s == N && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    check(tag);
  endtask

  task automatic feed(input logic d, input logic ov, input string tag);
    step(1'b0, 1'b1, d, ov, 1'b0, '0, tag);
  endtask

  task automatic expect_state(input int exp, input string tag);
    total++;
    assert (state === SW'(exp)) else begin
      bad++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp);
    end
  endtask

  initial begin
    bit s1 [7];
    int ov_exp [7];
    int nov_exp [7];
    s1      = '{1, 0, 1, 1, 0, 1, 1};
    ov_exp  = '{1, 2, 3, 4, 2, 3, 4};
    nov_exp = '{1, 2, 3, 4, 0, 1, 1};

    // Reset, then reset again mid-stream at state 3.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "reset0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "reset1");
    feed(1, 1, "pre_rst"); feed(0, 1, "pre_rst"); feed(1, 1, "pre_rst");
    expect_state(3, "pre_rst_s3");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, "mid_rst0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, "mid_rst1");
    expect_state(0, "mid_rst_s0");
    // Pattern must be back to 1101 after reset.
    feed(1, 1, "post_rst"); feed(0, 1, "post_rst"); feed(1, 1, "post_rst"); feed(1, 1, "post_rst");
    expect_state(4, "post_rst_full");

    // Overlapping stream.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "rst_ov");
    for (int i = 0; i < 7; i++) begin
      feed(s1[i], 1, "ov_stream");
      expect_state(ov_exp[i], "ov_seq");
    end

    // Non-overlapping stream.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "rst_nov");
    for (int i = 0; i < 7; i++) begin
      feed(s1[i], 0, "nov_stream");
      expect_state(nov_exp[i], "nov_seq");
    end

    // Gapped input with din toggling while invalid.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "rst_gap");
    for (int i = 0; i < 4; i++) begin
      feed(s1[i], 1, "gap_valid");
      for (int g = 0; g < 3; g++)
        step(1'b0, 1'b0, logic'(g[0]), 1'b1, 1'b0, '0, "gap_idle");
    end
    expect_state(4, "gap_hold");

    // pat_load beats a simultaneous valid bit, then 0000 pattern with overlap.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "rst_load");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, "load");
    expect_state(0, "load_s0");
    for (int i = 0; i < 6; i++) feed(0, 1, "zeros");

    // Saturation: five overlapping matches into a 2-bit counter.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "rst_sat");
    for (int i = 0; i < 4; i++) feed(s1[i], 1, "sat_first");
    for (int m = 0; m < 4; m++)
      for (int i = 4; i < 7; i++) feed(s1[i], 1, "sat_more");

    // Random stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, v, d, ov, ld;
      logic [N-1:0] pi;
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 75);
      d  = 1'($urandom);
      ov = ($urandom_range(0, 99) < 60);
      ld = ($urandom_range(0, 99) < 4);
      pi = N'($urandom);
      step(r, v, d, ov, ld, pi, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/moore_seq_det.md
# moore_seq_det

Parametrised Moore-type serial pattern detector. It is the generalised successor of the team's fixed 4-state Moore controller. It matches a runtime-loadable N-bit pattern on a qualified serial input, with selectable overlapping or non-overlapping detection, and keeps an optional saturating match counter. It sits on a serial control/data path and flags completed sequences to downstream logic.

## Interface
- N, 4, pattern length in bits; legal range 2..16
- CNT_W, 8, match counter width; legal range 1..16
- PAT_INIT, 4'b1101, pattern register value after reset; N bits wide; bit 0 is the first bit expected
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset; synchronous and active-high
- din_vld  input  1  din qualifier; a bit is accepted only when high
- din  input  1  serial data bit
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection
- pat_load  input  1  load pat_in into the pattern register
- pat_in  input  N  new pattern; bit 0 is the first bit expected
- qout  output  1  Moore match flag; high iff the state is N
- state  output  $clog2(N+1)  current matched-prefix length, 0..N
- match_cnt  output  CNT_W  number of matches, saturating

## Operation
- State S = length of the longest pattern prefix matched by the accepted bit history; S ranges 0..N.
- Transition, on an accepted bit b (din_vld=1, pat_load=0):
  - Form the candidate string = the first S' pattern bits followed by b.
  - S' = S when S<N.
  - When S=N: S' = N if overlap=1, S' = 0 if overlap=0.
  - Next S = largest k ≤ N such that the last k bits of the candidate equal pat[0..k-1]. This is failure-function behaviour, computed combinationally as a priority search from k=N down to 0.
- When din_vld=0, S holds and din is ignored.
- qout is derived from the registered state only: qout = (S==N). It has no combinational path from din.
- pat_load=1:
  - pattern register <= pat_in and S <= 0.
  - din is ignored that cycle, even if din_vld=1; pat_load has priority over din_vld.
  - match_cnt is not cleared.
- The overlap input is sampled on every accepted bit. Changing it mid-stream affects only the transition out of S=N.
- match_cnt increments by 1 on every cycle in which next S = N due to an accepted bit. This includes repeated matches while staying at N in overlap mode. It saturates at 2^CNT_W-1 and never wraps.
- rst has priority over everything:
  - S <= 0, qout <= 0, match_cnt <= 0, pattern register <= PAT_INIT.
  - A partial match in progress is discarded.

## Timing
- Reset values: qout=0, state=0, match_cnt=0, pattern register=PAT_INIT.
- Latency: the final pattern bit accepted at edge t gives qout=1 from edge t until the next accepted bit or pat_load.
- A single cycle that is both completing and re-matching (overlap, S=N to N) keeps qout high continuously, with no low glitch cycle.
- The pattern register, state and match_cnt all update on the same edge; pat_load and rst take effect at the next edge.
- Throughput: one bit per cycle; din_vld may be high continuously.

## Configuration
- MOORE_SEQ_CNT_EN defined: the match_cnt counter and its saturation logic are compiled in, behaving as above.
- MOORE_SEQ_CNT_EN undefined: no counter register exists, match_cnt is tied to 0, and all other behaviour is identical.

## Test plan
- Reset: all test plan items use N=4, pattern 4'b1101 (first bits expected 1,0,1,1). Drive rst for 2 cycles mid-stream with S=3 -> state=0, qout=0, match_cnt=0, pattern=4'b1101.
- Overlap=1 stream 1,0,1,1,0,1,1, din_vld held high -> state sequence 1,2,3,4,2,3,4; qout high after bits 4 and 7; match_cnt=2.
- Overlap=0, same stream -> state sequence 1,2,3,4,0,1,1; qout high after bit 4 only; match_cnt=1.
- Gapped input: stream 1,0,1,1 with din_vld=0 for 3 cycles between each bit while din toggles -> state advances only on valid cycles; qout rises after the 4th valid bit and holds through the following idle cycles.
- pat_load=1 with pat_in=4'b0000 and din_vld=1, din=1 in the same cycle -> state=0 and din is ignored. Then, with overlap=1, feed six 0s -> qout high after the 4th, 5th and 6th bits; match_cnt increments by 3.
- Saturation (CNT_W=2, overlap=1): produce 5 matches -> match_cnt reads 1,2,3,3,3. Rebuild without MOORE_SEQ_CNT_EN -> match_cnt stays 0 and qout is unchanged.
